// File: rtl/fpu_op_sequencer_if.sv
// Stream and FPU-side signals of the FPU issue sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface fpu_op_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [63:0]      IN_A;
  logic [63:0]      IN_B;
  logic [TAG_W-1:0] IN_TAG;
  logic [63:0]      FPU_A;
  logic [63:0]      FPU_B;
  logic [63:0]      FPU_O;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [63:0]      OUT_O;
  logic [TAG_W-1:0] OUT_TAG;

  modport master (
    output IN_VALID, IN_A, IN_B, IN_TAG, OUT_READY, FPU_O,
    input  IN_READY, FPU_A, FPU_B, OUT_VALID, OUT_O, OUT_TAG
  );

  modport slave (
    input  IN_VALID, IN_A, IN_B, IN_TAG, OUT_READY, FPU_O,
    output IN_READY, FPU_A, FPU_B, OUT_VALID, OUT_O, OUT_TAG
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Issue stage for a fixed-latency, non-stallable FPU: registers operands, tracks
// each op through the pipe and returns results in order through a credit-guarded FIFO.
module fpu_op_sequencer #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  fpu_op_sequencer_if.slave bus,
  output logic              BUSY,
  output logic [15:0]       DONE_CNT
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;

  logic [OCC_W-1:0]             occ;
  logic                         accept;
  logic                         pop;
  logic                         fifo_wr;
  logic                         fifo_empty;
  logic                         fifo_full;
  logic [LATENCY:0]             vld_pipe;
  logic [LATENCY:0][TAG_W-1:0]  tag_pipe;
  logic [AW:0]                  wr_ptr;
  logic [AW:0]                  rd_ptr;
  logic [63:0]                  mem_o   [FIFO_DEPTH];
  logic [TAG_W-1:0]             mem_tag [FIFO_DEPTH];

  // Credits cover in-flight and buffered ops, so the FPU can never overrun the FIFO.
  // Admission looks only at the registered count, never at OUT_READY.
  assign bus.IN_READY = (occ < OCC_W'(FIFO_DEPTH));
  assign accept       = bus.IN_VALID & bus.IN_READY;
  assign pop          = bus.OUT_VALID & bus.OUT_READY;
  assign BUSY         = (occ != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Operands hold between accepts to keep the FPU inputs quiet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.FPU_A <= '0;
      bus.FPU_B <= '0;
    end else if (accept) begin
      bus.FPU_A <= bus.IN_A;
      bus.FPU_B <= bus.IN_B;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= bus.IN_TAG;
      for (int i = 1; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Last stage lines up with the cycle FPU_O carries that op's result.
  assign fifo_wr    = vld_pipe[LATENCY];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_o[wr_ptr[AW-1:0]]   <= bus.FPU_O;
      mem_tag[wr_ptr[AW-1:0]] <= tag_pipe[LATENCY];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && fifo_wr) assert (!fifo_full);
  end

  // Show-ahead head; forced to zero when empty so stale entries never leak out.
  assign bus.OUT_VALID = !fifo_empty;
  assign bus.OUT_O     = bus.OUT_VALID ? mem_o[rd_ptr[AW-1:0]]   : '0;
  assign bus.OUT_TAG   = bus.OUT_VALID ? mem_tag[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge CLK) begin
    if (RST)      DONE_CNT <= '0;
    else if (pop) DONE_CNT <= DONE_CNT + 16'd1;
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench: LATENCY=4 sequencer with a registered adder FPU, plus a
// LATENCY=0 sequencer with a combinational adder for the short-pipe and wrap cases.
module tb_fpu_op_sequencer;
  logic        CLK = 1'b0;
  logic        RST, RST0;
  logic        BUSY, BUSY0;
  logic [15:0] DONE_CNT, DONE_CNT0;
  int          errors = 0;
  int          checks = 0;

  int          lat, rcv, last, n_acc, n_sent, n_pop, bad;
  logic        ok, gap, seen, acc, popq;
  logic [15:0] dc_last;
  logic [63:0] fpu_pipe [4];

  always #5 CLK = ~CLK;

  fpu_op_sequencer_if #(.TAG_W(4)) bus ();
  fpu_op_sequencer_if #(.TAG_W(4)) bus0 ();

  fpu_op_sequencer #(.LATENCY(4), .FIFO_DEPTH(8), .TAG_W(4)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .BUSY(BUSY), .DONE_CNT(DONE_CNT)
  );

  fpu_op_sequencer #(.LATENCY(0), .FIFO_DEPTH(8), .TAG_W(4)) dut0 (
    .CLK(CLK), .RST(RST0), .bus(bus0), .BUSY(BUSY0), .DONE_CNT(DONE_CNT0)
  );

  always @(posedge CLK) begin
    fpu_pipe[0] <= bus.FPU_A + bus.FPU_B;
    for (int i = 1; i < 4; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign bus.FPU_O  = fpu_pipe[3];
  assign bus0.FPU_O = bus0.FPU_A + bus0.FPU_B;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; RST0 = 1'b1;
    bus.IN_VALID = 0; bus.IN_A = '0; bus.IN_B = '0; bus.IN_TAG = '0; bus.OUT_READY = 0;
    bus0.IN_VALID = 0; bus0.IN_A = '0; bus0.IN_B = '0; bus0.IN_TAG = '0; bus0.OUT_READY = 0;
    repeat (3) step();
    RST = 1'b0;
    step();

    chk("rst_in_ready", bus.IN_READY, 1);
    chk("rst_fpu_a", bus.FPU_A, 0);
    chk("rst_fpu_b", bus.FPU_B, 0);
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_out_o", bus.OUT_O, 0);
    chk("rst_out_tag", bus.OUT_TAG, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done_cnt", DONE_CNT, 0);

    // single op, latency measured from the accept cycle
    bus.OUT_READY = 1;
    bus.IN_VALID = 1; bus.IN_A = 64'h3FF0000000000000; bus.IN_B = 64'd1; bus.IN_TAG = 4'd5;
    step(); lat = 1;
    bus.IN_VALID = 0;
    while (!bus.OUT_VALID && lat < 20) begin step(); lat++; end
    chk("t1_latency", lat, 6);
    chk("t1_out_o", bus.OUT_O, 64'h3FF0000000000001);
    chk("t1_out_tag", bus.OUT_TAG, 5);
    chk("t1_busy_held", BUSY, 1);
    step();
    chk("t1_done_cnt", DONE_CNT, 1);
    chk("t1_busy_after_pop", BUSY, 0);
    chk("t1_out_valid_after_pop", bus.OUT_VALID, 0);

    // 20 back-to-back ops at full throughput
    rcv = 0; last = -1; ok = 1; gap = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        bus.IN_VALID = 1; bus.IN_A = 64'(c); bus.IN_B = 64'd100; bus.IN_TAG = 4'(c);
        if (!bus.IN_READY) ok = 0;
      end else bus.IN_VALID = 0;
      step();
      if (bus.OUT_VALID) begin
        chk("t2_out_o", bus.OUT_O, 64'(100 + rcv));
        chk("t2_out_tag", bus.OUT_TAG, 64'(rcv % 16));
        if (rcv > 0 && c != last + 1) gap = 1;
        last = c;
        rcv++;
      end
    end
    chk("t2_in_ready_held", ok, 1);
    chk("t2_result_count", rcv, 20);
    chk("t2_consecutive", gap, 0);
    chk("t2_done_cnt", DONE_CNT, 21);

    // consumer stalled: only FIFO_DEPTH ops get in
    bus.OUT_READY = 0; n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      bus.IN_VALID = (n_acc < 10); bus.IN_A = 64'(n_acc); bus.IN_B = 64'd1000; bus.IN_TAG = 4'(n_acc);
      acc = bus.IN_VALID && bus.IN_READY;
      step();
      if (acc) n_acc++;
    end
    chk("t3_accepted", n_acc, 8);
    chk("t3_in_ready_full", bus.IN_READY, 0);
    chk("t3_out_valid", bus.OUT_VALID, 1);
    chk("t3_head", bus.OUT_O, 1000);
    chk("t3_busy", BUSY, 1);
    step();
    chk("t3_hold_o", bus.OUT_O, 1000);
    chk("t3_hold_tag", bus.OUT_TAG, 0);

    // full with a pop: no accept that cycle, accept the next
    bus.OUT_READY = 1;
    step();
    bus.OUT_READY = 0;
    chk("t4_pop_done_cnt", DONE_CNT, 22);
    chk("t4_no_accept", bus.IN_READY, 1);
    chk("t4_new_head", bus.OUT_O, 1001);
    step(); n_acc++;
    chk("t4_refull", bus.IN_READY, 0);

    // drain the rest in order while the last op is admitted
    rcv = 1; bus.OUT_READY = 1;
    for (int c = 0; c < 40; c++) begin
      bus.IN_VALID = (n_acc < 10); bus.IN_A = 64'(n_acc); bus.IN_B = 64'd1000; bus.IN_TAG = 4'(n_acc);
      acc  = bus.IN_VALID && bus.IN_READY;
      popq = bus.OUT_VALID;
      if (popq) begin
        chk("t3_drain_o", bus.OUT_O, 64'(1000 + rcv));
        chk("t3_drain_tag", bus.OUT_TAG, 64'(rcv));
      end
      step();
      if (acc) n_acc++;
      if (popq) rcv++;
    end
    chk("t3_drained", rcv, 10);
    chk("t3_all_accepted", n_acc, 10);
    chk("t3_busy_idle", BUSY, 0);
    chk("t3_done_cnt", DONE_CNT, 31);

    // reset with 2 buffered and 3 in flight
    bus.OUT_READY = 0;
    bus.IN_VALID = 1; bus.IN_A = 64'd1; bus.IN_B = 64'd1; bus.IN_TAG = 4'd1;
    step();
    bus.IN_A = 64'd2; bus.IN_TAG = 4'd2;
    step();
    bus.IN_VALID = 0;
    repeat (6) step();
    chk("t5_buffered", bus.OUT_VALID, 1);
    bus.IN_VALID = 1;
    for (int k = 3; k < 6; k++) begin
      bus.IN_A = 64'(k); bus.IN_TAG = 4'(k);
      step();
    end
    bus.IN_VALID = 0;
    RST = 1;
    step();
    RST = 0;
    chk("t5_out_valid", bus.OUT_VALID, 0);
    chk("t5_out_o", bus.OUT_O, 0);
    chk("t5_out_tag", bus.OUT_TAG, 0);
    chk("t5_fpu_a", bus.FPU_A, 0);
    chk("t5_fpu_b", bus.FPU_B, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_done_cnt", DONE_CNT, 0);
    chk("t5_in_ready", bus.IN_READY, 1);
    bus.OUT_READY = 1; seen = 0;
    repeat (12) begin
      step();
      if (bus.OUT_VALID) seen = 1;
    end
    chk("t5_no_late_result", seen, 0);
    chk("t5_done_cnt_after", DONE_CNT, 0);

    // LATENCY=0 build: 2-cycle latency, then DONE_CNT wrap
    RST0 = 0;
    step();
    chk("t6_rst_in_ready", bus0.IN_READY, 1);
    bus0.OUT_READY = 1;
    bus0.IN_VALID = 1; bus0.IN_A = 64'd7; bus0.IN_B = 64'd8; bus0.IN_TAG = 4'd3;
    step(); lat = 1;
    bus0.IN_VALID = 0;
    while (!bus0.OUT_VALID && lat < 10) begin step(); lat++; end
    chk("t6_latency", lat, 2);
    chk("t6_out_o", bus0.OUT_O, 15);
    chk("t6_out_tag", bus0.OUT_TAG, 3);
    step();
    chk("t6_first_pop", DONE_CNT0, 1);

    n_sent = 1; n_pop = 1; bad = 0; dc_last = '0;
    bus0.IN_B = '0;
    for (int c = 0; c < 70000 && n_pop < 65536; c++) begin
      bus0.IN_VALID = (n_sent < 65536); bus0.IN_A = 64'(n_sent); bus0.IN_TAG = 4'(n_sent);
      acc  = bus0.IN_VALID && bus0.IN_READY;
      popq = bus0.OUT_VALID;
      if (popq) begin
        if (bus0.OUT_O !== 64'(n_pop) || bus0.OUT_TAG !== 4'(n_pop)) bad++;
        if (n_pop == 65535) dc_last = DONE_CNT0;
      end
      step();
      if (acc) n_sent++;
      if (popq) n_pop++;
    end
    bus0.IN_VALID = 0;
    chk("t6_pop_count", n_pop, 65536);
    chk("t6_stream_data", bad, 0);
    chk("t6_done_cnt_ffff", dc_last, 16'hFFFF);
    chk("t6_done_cnt_wrap", DONE_CNT0, 0);
    chk("t6_busy_idle", BUSY0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Upstream issue stage for the FPU datapath: accepts operand pairs on a valid/ready stream and drives registered A/B into the FPU.
- Tracks each operation through the FPU's fixed pipeline latency, then captures the FPU result into a result FIFO.
- Returns results in issue order, with tags, on a valid/ready output stream.
- Credit-based admission guarantees the result FIFO can never overflow, even while the FPU cannot stall.

Parameters:
- LATENCY, 4, register stages inside the FPU from A/B to O. Legal range 0..15; 0 means O is combinational from A/B.
- FIFO_DEPTH, 8, result FIFO entries. Power of two, 2..64; also the maximum number of operations outstanding (in flight plus buffered).
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  sequencer can accept an operand pair.
- IN_A  in  64  operand A.
- IN_B  in  64  operand B.
- IN_TAG  in  TAG_W  user tag returned with the result.
- FPU_A  out  64  registered operand A to the FPU.
- FPU_B  out  64  registered operand B to the FPU.
- FPU_O  in  64  FPU result.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer accepts the result.
- OUT_O  out  64  result data.
- OUT_TAG  out  TAG_W  tag of the result.
- BUSY  out  1  at least one operation outstanding.
- DONE_CNT  out  16  count of delivered results.

Behaviour:
Timing base:
- Single clock CLK.
- RST is synchronous and active-high. It clears every register on the next edge and discards all in-flight and buffered operations.

Reset values:
- IN_READY = 1 (once RST is deasserted).
- FPU_A = 0, FPU_B = 0.
- OUT_VALID = 0, OUT_O = 0, OUT_TAG = 0.
- BUSY = 0, DONE_CNT = 0.

Occupancy counter OCC (0..FIFO_DEPTH):
- Increments on accept (IN_VALID & IN_READY).
- Decrements on pop (OUT_VALID & OUT_READY).
- Accept and pop in the same cycle leave OCC unchanged.

Admission:
- IN_READY = (OCC < FIFO_DEPTH), decoded from registers only.
- IN_READY has no combinational path from OUT_READY. At OCC == FIFO_DEPTH, IN_READY is 0 even if a pop occurs in that cycle.

Issue:
- On the accept edge, FPU_A <= IN_A and FPU_B <= IN_B.
- In cycles without an accept, FPU_A and FPU_B hold their values, to minimise toggling.

Tracking:
- A shift register of LATENCY+1 stages carries {valid, tag}.
- Stage 0 loads {accept, IN_TAG} on every edge.
- When the last stage is valid, FPU_O is sampled and written, together with its tag, into the FIFO on that edge.
- Result: for an accept at edge t, the FIFO write occurs at edge t+1+LATENCY.
- Back-to-back accepts issue one operation per cycle, giving full throughput.

Result FIFO:
- Show-ahead: OUT_O and OUT_TAG are valid whenever OUT_VALID = !empty.
- Write and read in the same cycle are legal, including when the FIFO is empty (the new entry is visible the next cycle; no bypass) and when it is full.
- Overflow is impossible by construction. An assertion shall flag a write while full.

Latency and ordering:
- Minimum accept-to-OUT_VALID latency is LATENCY+2 cycles.
- Results are delivered strictly in issue order.

Status:
- BUSY = (OCC != 0).
- DONE_CNT increments on each pop and wraps from 0xFFFF to 0.

Stability rules:
- IN_A, IN_B and IN_TAG are sampled only on accept.
- OUT_O and OUT_TAG must remain stable while OUT_VALID=1 and OUT_READY=0.

Reset mid-operation:
- In-flight results arriving after RST are dropped, because the shift register has been cleared.
- OUT_VALID falls on the reset edge.

Test Plan:
Bench FPU model: O = A + B (64-bit integer), LATENCY=4 register stages. Default parameters unless stated.
1. Single op, A=0x3FF0000000000000, B=1, tag=5, OUT_READY=1 -> OUT_VALID rises 6 cycles after accept with OUT_O=0x3FF0000000000001, OUT_TAG=5; DONE_CNT=1; BUSY=0 the cycle after the pop.
2. 20 back-to-back ops (A=i, B=100, tag=i%16), OUT_READY=1 -> IN_READY stays 1 throughout; results 100..119 arrive on consecutive cycles, in order.
3. OUT_READY=0 with 10 ops offered -> exactly 8 accepted, IN_READY=0 at OCC=8, 8 results buffered; raising OUT_READY drains all 8 in order, then the remaining 2 are accepted.
4. OCC=8, IN_VALID=1, OUT_READY=1 for one cycle -> pop occurs and no accept that cycle; the accept occurs on the next cycle with OCC returning to 8.
5. RST asserted for 1 cycle with 3 ops in flight and 2 buffered -> all outputs return to reset values; no result appears afterwards; DONE_CNT=0.
6. LATENCY=0 build, FPU model combinational -> result arrives 2 cycles after accept; DONE_CNT wraps to 0 after 65536 pops.
